wb_ctrl: RTL and testbench

Write-back controller that drives the register-file write port (enable, address, data) from two result sources.
- The single-cycle execute path is always accepted.
- A long-latency unit (load/store or divider) delivers results over a valid/ready handshake and is buffered in a small in-order queue.
- The block enforces write-after-write ordering between the two sources.
- It exports a busy mask so decode can stall on registers that still have queued writes.

---
 rtl/wb_ctrl.sv | 118 +++++++++++
 tb/tb_wb_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
// wb_ctrl: register-file write-back from execute and a queued long-latency source, with WAW kill.
// Optional `WB_STALL_CNT_EN adds stall_cnt_o counting cycles of lsu_valid_i while not ready.
module wb_ctrl #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NREG  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_wen_i,
    input  logic [AW-1:0]   ex_waddr_i,
    input  logic [DW-1:0]   ex_wdata_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [AW-1:0]   lsu_waddr_i,
    input  logic [DW-1:0]   lsu_wdata_i,
    output logic            wen_o,
    output logic [AW-1:0]   w_addr_o,
    output logic [DW-1:0]   w_data_o,
    output logic [NREG-1:0] busy_o
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o
`endif
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0]         ent_v_q, ent_v_d;
    logic [DEPTH-1:0][AW-1:0] ent_a_q, ent_a_d;
    logic [DEPTH-1:0][DW-1:0] ent_d_q, ent_d_d;
    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     wen_q, wen_d;
    logic [AW-1:0]            w_addr_q, w_addr_d;
    logic [DW-1:0]            w_data_q, w_data_d;
    logic ex_req, xfer, lsu_live, empty, sel_ex, sel_head, sel_dir, push, pop;

    assign lsu_ready_o = count_q < CW'(DEPTH);
    assign wen_o       = wen_q;
    assign w_addr_o    = w_addr_q;
    assign w_data_o    = w_data_q;

    always_comb begin
        ex_req   = ex_wen_i && ex_waddr_i != '0;
        xfer     = lsu_valid_i && lsu_ready_o;
        // a same-cycle ex write to the same register supersedes the lsu result
        lsu_live = xfer && lsu_waddr_i != '0 && !(ex_req && lsu_waddr_i == ex_waddr_i);
        empty    = count_q == '0;
        sel_ex   = ex_req;
        sel_head = !ex_req && !empty && ent_v_q[head_q];
        sel_dir  = !ex_req && empty && lsu_live;
        pop      = !empty && (sel_head || !ent_v_q[head_q]);
        push     = lsu_live && !sel_dir;
        wen_d    = sel_ex || sel_head || sel_dir;
        w_addr_d = sel_ex ? ex_waddr_i : sel_head ? ent_a_q[head_q] : sel_dir ? lsu_waddr_i : w_addr_q;
        w_data_d = sel_ex ? ex_wdata_i : sel_head ? ent_d_q[head_q] : sel_dir ? lsu_wdata_i : w_data_q;
        ent_v_d  = ent_v_q;
        ent_a_d  = ent_a_q;
        ent_d_d  = ent_d_q;
        for (int i = 0; i < DEPTH; i++)
            if (ex_req && ent_a_q[i] == ex_waddr_i) ent_v_d[i] = 1'b0;
        if (pop) ent_v_d[head_q] = 1'b0;
        if (push) begin
            ent_v_d[tail_q] = 1'b1;
            ent_a_d[tail_q] = lsu_waddr_i;
            ent_d_d[tail_q] = lsu_wdata_i;
        end
        head_d  = pop ? (head_q == LAST ? '0 : head_q + 1'b1) : head_q;
        tail_d  = push ? (tail_q == LAST ? '0 : tail_q + 1'b1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        busy_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_v_q[i]) busy_o[ent_a_q[i]] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_v_q  <= '0;
            ent_a_q  <= '0;
            ent_d_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wen_q    <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            ent_v_q  <= ent_v_d;
            ent_a_q  <= ent_a_d;
            ent_d_q  <= ent_d_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    assign stall_cnt_o = stall_q;

    always_comb stall_d = stall_q + 32'(lsu_valid_i && !lsu_ready_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end
`endif
endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: scoreboard bench for wb_ctrl; expected register-file writes are queued in issue order.
module tb_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_wen_i = 1'b0;
    logic [4:0]  ex_waddr_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_waddr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        wen_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;
    logic [31:0] busy_o;
`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];

    wb_ctrl #(.DEPTH(2), .AW(5), .DW(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .ex_wen_i(ex_wen_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .wen_o(wen_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o), .busy_o(busy_o)
`ifdef WB_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        ex_wen_i = ew; ex_waddr_i = ea; ex_wdata_i = ed;
        lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] wr(input logic [4:0] a, input logic [31:0] d);
        return {a, d};
    endfunction

    // Monitor: every issued write must match the oldest expected write.
    always @(negedge clk) begin
        if (wen_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected x%0d=0x%0h, expected none", w_addr_o, w_data_o);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({w_addr_o, w_data_o} !== e) begin
                    errors++;
                    $display("FAIL write: got x%0d=0x%0h, expected x%0d=0x%0h",
                             w_addr_o, w_data_o, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset_wen", wen_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_waddr", w_addr_o, 0);
        chk("reset_wdata", w_data_o, 0);
        tick; tick;
        rst = 1'b0;
        tick;
        chk("idle_ready", lsu_ready_o, 1);

        // Direct path
        drive(0, 0, 0, 1, 5, 32'h1234);
        exp_q.push_back(wr(5, 32'h1234));
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("direct_wen", wen_o, 1);
        chk("direct_busy", busy_o, 0);
        tick;
        chk("hold_wen", wen_o, 0);
        chk("hold_waddr", w_addr_o, 5);
        chk("hold_wdata", w_data_o, 32'h1234);

        // Contention with DEPTH=2
        for (int i = 0; i < 3; i++) exp_q.push_back(wr(3, 32'hA));
        exp_q.push_back(wr(7, 1));
        exp_q.push_back(wr(8, 2));
        exp_q.push_back(wr(9, 3));
        drive(1, 3, 32'hA, 1, 7, 1);
        chk("cont_ready_c1", lsu_ready_o, 1);
        tick;
        drive(1, 3, 32'hA, 1, 8, 2);
        chk("cont_ready_c2", lsu_ready_o, 1);
        chk("cont_busy_c2", busy_o, 32'h80);
        tick;
        drive(1, 3, 32'hA, 1, 9, 3);
        chk("cont_ready_c3", lsu_ready_o, 0);
        chk("cont_busy_c3", busy_o, 32'h180);
        tick;
        drive(0, 0, 0, 1, 9, 3);
        chk("cont_ready_c4", lsu_ready_o, 0);
        tick;
        chk("cont_ready_c5", lsu_ready_o, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        tick; tick; tick;
        chk("cont_busy_end", busy_o, 0);

        // WAW kill
        exp_q.push_back(wr(3, 32'h5));
        exp_q.push_back(wr(4, 32'h22));
        drive(1, 3, 32'h5, 1, 4, 32'h11);
        tick;
        chk("waw_busy_set", busy_o, 32'h10);
        drive(1, 4, 32'h22, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("waw_busy_clr", busy_o, 0);
        tick; tick;
        chk("waw_wen_idle", wen_o, 0);
        chk("waw_ready", lsu_ready_o, 1);

        // Same-cycle lsu transfer to ex's register is discarded
        exp_q.push_back(wr(6, 32'h66));
        drive(1, 6, 32'h66, 1, 6, 32'h77);
        chk("waw_lsu_ready", lsu_ready_o, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("waw_lsu_busy", busy_o, 0);
        tick; tick;

        // x0 filter
        drive(1, 0, 32'hFF, 1, 0, 32'hEE);
        chk("x0_ready", lsu_ready_o, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("x0_wen", wen_o, 0);
        chk("x0_busy", busy_o, 0);
        tick;
        chk("x0_wen2", wen_o, 0);

`ifdef WB_STALL_CNT_EN
        chk("stall_zero", stall_cnt_o, 0);
        for (int i = 0; i < 7; i++) exp_q.push_back(wr(3, 32'hB));
        exp_q.push_back(wr(10, 32'h10));
        exp_q.push_back(wr(11, 32'h11));
        drive(1, 3, 32'hB, 1, 10, 32'h10);
        tick;
        drive(1, 3, 32'hB, 1, 11, 32'h11);
        tick;
        drive(1, 3, 32'hB, 1, 12, 32'h12);
        for (int i = 0; i < 5; i++) tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("stall_cnt", stall_cnt_o, 5);
        tick; tick; tick;
`endif

        // Mid-operation reset drops queued work
        exp_q.push_back(wr(3, 32'h55));
        drive(1, 3, 32'h55, 1, 6, 32'h66);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_busy_pre", busy_o, 32'h40);
        #6;
        rst = 1'b1;
        #1;
        chk("mid_wen", wen_o, 0);
        chk("mid_busy", busy_o, 0);
        tick;
        #3;
        rst = 1'b0;
        tick;
        chk("mid_ready", lsu_ready_o, 1);
        tick; tick; tick;
        chk("mid_no_write", wen_o, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
